aidc_lite_code_packer: RTL

//  Packs variable-length compressed code fragments into fixed WORD_W-bit words for one block.

---
 rtl/aidc_lite_pkg.sv | 13 +
 rtl/aidc_lite_bit_aligner.sv | 26 ++
 rtl/aidc_lite_code_packer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/aidc_lite_pkg.sv
// Shared constants and block-status type for the AIDC-Lite code packer.
package aidc_lite_pkg;
    localparam int AIDC_WORD_W    = 64;
    localparam int AIDC_MAX_WORDS = 8;
    localparam int AIDC_PREFIX_W  = 2;
    localparam int AIDC_WORDS_W   = $clog2(AIDC_MAX_WORDS) + 1;

    typedef struct packed {
        logic                    done;
        logic                    fail;
        logic [AIDC_WORDS_W-1:0] words;
    } aidc_blk_status_t;
endpackage

// File: rtl/aidc_lite_bit_aligner.sv
// Combinational merge of the top size_i bits of an MSB-aligned fragment into
// an MSB-aligned buffer, starting right after its buf_size_i valid bits.
module aidc_lite_bit_aligner
    import aidc_lite_pkg::*;
#(
    parameter int BUF_W     = 130,
    parameter int DATA_SIZE = 66,
    parameter int SIZE_W    = 7,
    parameter int BSZ_W     = 8
) (
    input  logic [BUF_W-1:0]     buf_i,
    input  logic [BSZ_W-1:0]     buf_size_i,
    input  logic [DATA_SIZE-1:0] data_i,
    input  logic [SIZE_W-1:0]    size_i,
    output logic [BUF_W-1:0]     buf_o
);
    logic [DATA_SIZE-1:0] mask;
    logic [BUF_W-1:0]     ext;

    // Buffer bits below buf_size_i are always zero, so OR is a safe merge.
    always_comb begin
        mask  = ~({DATA_SIZE{1'b1}} >> size_i);
        ext   = {data_i & mask, {(BUF_W-DATA_SIZE){1'b0}}};
        buf_o = buf_i | (ext >> buf_size_i);
    end
endmodule

// File: rtl/aidc_lite_code_packer.sv
// Packs MSB-aligned code fragments into WORD_W-bit words per block, prefixed,
// with valid/ready on both sides and done/fail/word-count reporting.
module aidc_lite_code_packer
    import aidc_lite_pkg::*;
#(
    parameter int                  PREFIX_W  = AIDC_PREFIX_W,
    parameter logic [PREFIX_W-1:0] PREFIX    = '0,
    parameter int                  DATA_SIZE = 66,
    parameter int                  WORD_W    = AIDC_WORD_W,
    parameter int                  MAX_WORDS = AIDC_MAX_WORDS,
    parameter int                  SIZE_W    = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         sop_i,
    input  logic                         eop_i,
    input  logic [DATA_SIZE-1:0]         data_i,
    input  logic [SIZE_W-1:0]            size_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(MAX_WORDS)-1:0] addr_o,
    output logic [WORD_W-1:0]            data_o,
    output logic                         done_o,
    output logic                         fail_o,
    output logic [$clog2(MAX_WORDS):0]   words_o
);
    localparam int ADDR_W = $clog2(MAX_WORDS);
    localparam int CNT_W  = $clog2(MAX_WORDS) + 1;
    localparam int BUF_W  = WORD_W + DATA_SIZE;
    localparam int BSZ_W  = $clog2(BUF_W + 1);
    localparam int BLK_W  = $clog2(MAX_WORDS * WORD_W + DATA_SIZE + 1) + 1;

    localparam logic [BUF_W-1:0]  BUF_INIT  = {PREFIX, {(BUF_W-PREFIX_W){1'b0}}};
    localparam logic [BSZ_W-1:0]  WORD_SZ   = BSZ_W'(WORD_W);
    localparam logic [BSZ_W-1:0]  PRE_SZ    = BSZ_W'(PREFIX_W);
    localparam logic [BLK_W-1:0]  PRE_BLK   = BLK_W'(PREFIX_W);
    localparam logic [BLK_W-1:0]  BLK_LIMIT = BLK_W'(MAX_WORDS * WORD_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_WORDS);
    localparam logic [SIZE_W-1:0] SIZE_MAX  = SIZE_W'(DATA_SIZE);

    logic [BUF_W-1:0]  buf_q, buf_d, base_buf, merged_buf;
    logic [BSZ_W-1:0]  bsz_q, bsz_d, base_bsz, merged_bsz;
    logic [BLK_W-1:0]  blk_q, blk_d, base_blk, merged_blk;
    logic [BLK_W:0]    blk_sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flush_q, flush_d, fail_q, fail_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] word_q, word_d;
    aidc_blk_status_t  stat_q, stat_d;
    logic [SIZE_W-1:0] size_c, add_sz;
    logic              slot_free, accept, sop_acc, finish;

    assign slot_free = ~valid_q | ready_i;
    assign ready_o   = (bsz_q < WORD_SZ) & ~flush_q & slot_free;
    assign accept    = valid_i & ready_o;
    assign sop_acc   = accept & sop_i;
    assign size_c    = (size_i > SIZE_MAX) ? SIZE_MAX : size_i;
    assign add_sz    = accept ? size_c : '0;

    // A sop restarts from the prefix; whatever the open block held is dropped.
    always_comb begin
        if (sop_acc) begin
            base_buf = BUF_INIT;
            base_bsz = PRE_SZ;
            base_blk = PRE_BLK;
        end else begin
            base_buf = buf_q;
            base_bsz = bsz_q;
            base_blk = blk_q;
        end
    end

    aidc_lite_bit_aligner #(
        .BUF_W    (BUF_W),
        .DATA_SIZE(DATA_SIZE),
        .SIZE_W   (SIZE_W),
        .BSZ_W    (BSZ_W)
    ) u_aligner (
        .buf_i     (base_buf),
        .buf_size_i(base_bsz),
        .data_i    (data_i),
        .size_i    (add_sz),
        .buf_o     (merged_buf)
    );

    assign merged_bsz = base_bsz + BSZ_W'(add_sz);
    assign blk_sum    = {1'b0, base_blk} + (BLK_W+1)'(add_sz);
    assign merged_blk = blk_sum[BLK_W] ? '1 : blk_sum[BLK_W-1:0];

    // Emission works on the post-append buffer so a completing fragment's
    // word is loaded on the same edge that accepts it.
    always_comb begin
        buf_d   = merged_buf;
        bsz_d   = merged_bsz;
        blk_d   = merged_blk;
        cnt_d   = sop_acc ? '0 : cnt_q;
        fail_d  = sop_acc ? 1'b0 : fail_q;
        flush_d = flush_q | (accept & eop_i);
        valid_d = valid_q & ~ready_i;
        addr_d  = addr_q;
        word_d  = word_q;
        stat_d  = stat_q;
        stat_d.done = 1'b0;
        finish  = 1'b0;

        if (merged_bsz >= WORD_SZ && slot_free) begin
            if (cnt_d < CNT_MAX) begin
                word_d  = merged_buf[BUF_W-1 -: WORD_W];
                addr_d  = cnt_d[ADDR_W-1:0];
                valid_d = 1'b1;
                cnt_d   = cnt_d + CNT_W'(1);
            end else begin
                fail_d  = 1'b1;
            end
            buf_d  = merged_buf << WORD_W;
            bsz_d  = merged_bsz - WORD_SZ;
            finish = flush_d & (bsz_d == '0);
        end else if (merged_bsz < WORD_SZ && flush_d &&
                     (slot_free || merged_bsz == '0 || cnt_d >= CNT_MAX)) begin
            // Residual bits become one zero-padded word if there is room.
            if (merged_bsz != '0 && cnt_d < CNT_MAX) begin
                word_d  = merged_buf[BUF_W-1 -: WORD_W];
                addr_d  = cnt_d[ADDR_W-1:0];
                valid_d = 1'b1;
                cnt_d   = cnt_d + CNT_W'(1);
            end
            finish = 1'b1;
        end

        if (finish) begin
            stat_d.done  = 1'b1;
            stat_d.fail  = fail_d | (merged_blk > BLK_LIMIT);
            stat_d.words = AIDC_WORDS_W'(cnt_d);
            buf_d   = BUF_INIT;
            bsz_d   = PRE_SZ;
            blk_d   = PRE_BLK;
            cnt_d   = '0;
            fail_d  = 1'b0;
            flush_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= BUF_INIT;
            bsz_q   <= PRE_SZ;
            blk_q   <= PRE_BLK;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            fail_q  <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            word_q  <= '0;
            stat_q  <= '0;
        end else begin
            buf_q   <= buf_d;
            bsz_q   <= bsz_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            fail_q  <= fail_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            stat_q  <= stat_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = word_q;
    assign done_o  = stat_q.done;
    assign fail_o  = stat_q.fail;
    assign words_o = CNT_W'(stat_q.words);
endmodule
